serial_bridge: RTL and testbench

SERIAL_BRIDGE -- requirements
Module: serial_bridge

---
 rtl/serial_bridge_pkg.sv | 9 +
 rtl/byte_fifo.sv | 63 ++++++
 rtl/serial_bridge.sv | 85 ++++++++
 tb/tb_serial_bridge.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_bridge_pkg.sv
// Shared constants and types for the serial bridge.
package serial_bridge_pkg;

    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned DEPTH_DEFAULT = 8;

    typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO: head_data is the oldest stored byte with no read latency.
module byte_fifo
    import serial_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  logic [BYTE_W-1:0]       push_data,
    input  logic                    pop,
    output logic [BYTE_W-1:0]       head_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    // Full/empty come straight from the registered count, so there is no
    // path from a same-cycle pop into the push acceptance.
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Storage write; contents are not cleared by reset.
    always_ff @(posedge clock) begin
        if (reset && push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_bridge.sv
// Host <-> processor byte bridge: RX and TX FIFOs plus sticky error flags.
module serial_bridge
    import serial_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [BYTE_W-1:0]       host_rx_data,
    input  logic                    host_rx_valid,
    output logic                    host_rx_ready,
    output logic [BYTE_W-1:0]       proc_rx_data,
    output logic                    proc_rx_valid,
    input  logic                    proc_rx_rden,
    input  logic [BYTE_W-1:0]       proc_tx_data,
    input  logic                    proc_tx_wren,
    output logic                    proc_tx_ready,
    output logic [BYTE_W-1:0]       host_tx_data,
    output logic                    host_tx_valid,
    input  logic                    host_tx_ready,
    output logic [$clog2(DEPTH):0]  rx_count,
    output logic [$clog2(DEPTH):0]  tx_count,
    output logic                    err_underflow,
    output logic                    err_overflow
);

    logic rx_full;
    logic rx_empty;
    logic tx_full;
    logic tx_empty;
    logic rx_push;
    logic rx_pop;
    logic tx_push;
    logic tx_pop;

    // Handshake gating: a transfer needs both sides of the handshake.
    assign host_rx_ready = !rx_full;
    assign proc_rx_valid = !rx_empty;
    assign proc_tx_ready = !tx_full;
    assign host_tx_valid = !tx_empty;
    assign rx_push       = host_rx_valid && host_rx_ready;
    assign rx_pop        = proc_rx_rden && proc_rx_valid;
    assign tx_push       = proc_tx_wren && proc_tx_ready;
    assign tx_pop        = host_tx_valid && host_tx_ready;

    byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rx_push),
        .push_data (host_rx_data),
        .pop       (rx_pop),
        .head_data (proc_rx_data),
        .count     (rx_count),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tx_push),
        .push_data (proc_tx_data),
        .pop       (tx_pop),
        .head_data (host_tx_data),
        .count     (tx_count),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    // Sticky processor-side protocol errors; host side is gated and cannot err.
    always_ff @(posedge clock) begin
        if (!reset) begin
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            if (proc_rx_rden && !proc_rx_valid) begin
                err_underflow <= 1'b1;
            end
            if (proc_tx_wren && !proc_tx_ready) begin
                err_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_bridge.sv
// Self-checking bench for serial_bridge against a queue-based reference model.
module tb_serial_bridge;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             clock;
    logic             reset;
    logic [7:0]       host_rx_data;
    logic             host_rx_valid;
    logic             host_rx_ready;
    logic [7:0]       proc_rx_data;
    logic             proc_rx_valid;
    logic             proc_rx_rden;
    logic [7:0]       proc_tx_data;
    logic             proc_tx_wren;
    logic             proc_tx_ready;
    logic [7:0]       host_tx_data;
    logic             host_tx_valid;
    logic             host_tx_ready;
    logic [CNT_W-1:0] rx_count;
    logic [CNT_W-1:0] tx_count;
    logic             err_underflow;
    logic             err_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    bit         m_udf;
    bit         m_ovf;

    serial_bridge #(.DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .host_rx_data  (host_rx_data),
        .host_rx_valid (host_rx_valid),
        .host_rx_ready (host_rx_ready),
        .proc_rx_data  (proc_rx_data),
        .proc_rx_valid (proc_rx_valid),
        .proc_rx_rden  (proc_rx_rden),
        .proc_tx_data  (proc_tx_data),
        .proc_tx_wren  (proc_tx_wren),
        .proc_tx_ready (proc_tx_ready),
        .host_tx_data  (host_tx_data),
        .host_tx_valid (host_tx_valid),
        .host_tx_ready (host_tx_ready),
        .rx_count      (rx_count),
        .tx_count      (tx_count),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle();
        host_rx_valid = 1'b0;
        host_rx_data  = 8'h00;
        proc_rx_rden  = 1'b0;
        proc_tx_wren  = 1'b0;
        proc_tx_data  = 8'h00;
        host_tx_ready = 1'b0;
    endtask

    // One clock edge: model decides from pre-edge state, then outputs settle.
    task automatic tick();
        bit rx_push, rx_pop, tx_push, tx_pop, udf, ovf;
        logic [7:0] rxd, txd;
        rx_push = host_rx_valid && (rx_q.size() < DEPTH);
        rx_pop  = proc_rx_rden && (rx_q.size() > 0);
        tx_push = proc_tx_wren && (tx_q.size() < DEPTH);
        tx_pop  = host_tx_ready && (tx_q.size() > 0);
        udf     = proc_rx_rden && (rx_q.size() == 0);
        ovf     = proc_tx_wren && (tx_q.size() == DEPTH);
        rxd     = host_rx_data;
        txd     = proc_tx_data;
        @(posedge clock);
        #1;
        if (!reset) begin
            rx_q.delete();
            tx_q.delete();
            m_udf = 0;
            m_ovf = 0;
        end else begin
            if (rx_pop)  void'(rx_q.pop_front());
            if (rx_push) rx_q.push_back(rxd);
            if (tx_pop)  void'(tx_q.pop_front());
            if (tx_push) tx_q.push_back(txd);
            if (udf) m_udf = 1;
            if (ovf) m_ovf = 1;
        end
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        host_rx_valid = 1'b1;
        proc_tx_wren  = 1'b1;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        idle();
        n_checks++;
        if (host_rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_host_rx_ready got %b want 1", host_rx_ready); end
        n_checks++;
        if (proc_tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_proc_tx_ready got %b want 1", proc_tx_ready); end
        n_checks++;
        if (proc_rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_proc_rx_valid got %b want 0", proc_rx_valid); end
        n_checks++;
        if (host_tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_host_tx_valid got %b want 0", host_tx_valid); end
        n_checks++;
        if (rx_count !== '0 || tx_count !== '0) begin n_fail++; $display("FAIL reset_counts got %0d/%0d want 0/0", rx_count, tx_count); end
        n_checks++;
        if (err_underflow !== 1'b0 || err_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %b%b want 00", err_underflow, err_overflow); end
    endtask

    task automatic test_rx_basic();
        do_reset();
        host_rx_valid = 1'b1;
        host_rx_data  = 8'h41;
        tick();
        n_checks++;
        if (proc_rx_valid !== 1'b1 || proc_rx_data !== 8'h41) begin n_fail++; $display("FAIL rx_first_visible got v=%b d=%h want v=1 d=41", proc_rx_valid, proc_rx_data); end
        host_rx_data = 8'h42;
        tick();
        idle();
        n_checks++;
        if (rx_count !== CNT_W'(2)) begin n_fail++; $display("FAIL rx_count_two got %0d want 2", rx_count); end
        proc_rx_rden = 1'b1;
        n_checks++;
        if (proc_rx_data !== 8'h41) begin n_fail++; $display("FAIL rx_pop0 got %h want 41", proc_rx_data); end
        tick();
        n_checks++;
        if (proc_rx_data !== 8'h42) begin n_fail++; $display("FAIL rx_pop1 got %h want 42", proc_rx_data); end
        tick();
        idle();
        n_checks++;
        if (rx_count !== '0 || proc_rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx_drained got cnt=%0d v=%b want 0/0", rx_count, proc_rx_valid); end
    endtask

    task automatic test_tx_overflow();
        do_reset();
        proc_tx_wren = 1'b1;
        for (int i = 0; i < 8; i++) begin
            proc_tx_data = 8'(i);
            tick();
        end
        n_checks++;
        if (tx_count !== CNT_W'(8) || proc_tx_ready !== 1'b0) begin n_fail++; $display("FAIL tx_full got cnt=%0d rdy=%b want 8/0", tx_count, proc_tx_ready); end
        n_checks++;
        if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL tx_no_early_ovf got %b want 0", err_overflow); end
        proc_tx_data = 8'hFF;
        tick();
        idle();
        n_checks++;
        if (err_overflow !== 1'b1 || tx_count !== CNT_W'(8)) begin n_fail++; $display("FAIL tx_overflow got ovf=%b cnt=%0d want 1/8", err_overflow, tx_count); end
        host_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (host_tx_valid !== 1'b1 || host_tx_data !== 8'(i)) begin n_fail++; $display("FAIL tx_drain%0d got v=%b d=%h want 1/%h", i, host_tx_valid, host_tx_data, 8'(i)); end
            tick();
        end
        n_checks++;
        if (host_tx_valid !== 1'b0 || tx_count !== '0) begin n_fail++; $display("FAIL tx_drained got v=%b cnt=%0d want 0/0", host_tx_valid, tx_count); end
        idle();
    endtask

    task automatic test_wrap();
        logic [7:0] exp;
        do_reset();
        host_rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            host_rx_data = 8'($urandom);
            tick();
        end
        proc_rx_rden = 1'b1;
        for (int i = 0; i < 10; i++) begin
            host_rx_data = 8'($urandom);
            exp = rx_q[0];
            n_checks++;
            if (proc_rx_data !== exp) begin n_fail++; $display("FAIL wrap_data%0d got %h want %h", i, proc_rx_data, exp); end
            tick();
            n_checks++;
            if (rx_count !== CNT_W'(3)) begin n_fail++; $display("FAIL wrap_count%0d got %0d want 3", i, rx_count); end
        end
        idle();
    endtask

    task automatic test_underflow();
        do_reset();
        proc_rx_rden = 1'b1;
        tick();
        idle();
        n_checks++;
        if (err_underflow !== 1'b1 || rx_count !== '0) begin n_fail++; $display("FAIL underflow got udf=%b cnt=%0d want 1/0", err_underflow, rx_count); end
        for (int i = 0; i < 20; i++) tick();
        n_checks++;
        if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_sticky got %b want 1", err_underflow); end
        n_checks++;
        if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL underflow_no_ovf got %b want 0", err_overflow); end
    endtask

    task automatic test_full_refuse();
        do_reset();
        host_rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            host_rx_data = 8'h10 + 8'(i);
            tick();
        end
        n_checks++;
        if (host_rx_ready !== 1'b0 || rx_count !== CNT_W'(8)) begin n_fail++; $display("FAIL rx_full got rdy=%b cnt=%0d want 0/8", host_rx_ready, rx_count); end
        host_rx_data = 8'hEE;
        proc_rx_rden = 1'b1;
        tick();
        idle();
        n_checks++;
        if (rx_count !== CNT_W'(7) || host_rx_ready !== 1'b1) begin n_fail++; $display("FAIL rx_refuse got cnt=%0d rdy=%b want 7/1", rx_count, host_rx_ready); end
        proc_rx_rden = 1'b1;
        for (int i = 1; i < 8; i++) begin
            n_checks++;
            if (proc_rx_data !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL rx_refuse_order%0d got %h want %h", i, proc_rx_data, 8'h10 + 8'(i)); end
            tick();
        end
        n_checks++;
        if (proc_rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx_refuse_extra got v=%b d=%h want empty", proc_rx_valid, proc_rx_data); end
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        host_rx_valid = 1'b1;
        proc_tx_wren  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            host_rx_valid = (i < 4);
            host_rx_data  = 8'($urandom);
            proc_tx_data  = 8'($urandom);
            tick();
        end
        idle();
        host_tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        idle();
        n_checks++;
        if (rx_count !== CNT_W'(4) || tx_count !== CNT_W'(4) || err_overflow !== 1'b1) begin n_fail++; $display("FAIL mid_setup got rx=%0d tx=%0d ovf=%b want 4/4/1", rx_count, tx_count, err_overflow); end
        host_rx_valid = 1'b1;
        proc_tx_wren  = 1'b1;
        proc_rx_rden  = 1'b1;
        host_tx_ready = 1'b1;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        idle();
        n_checks++;
        if (rx_count !== '0 || tx_count !== '0) begin n_fail++; $display("FAIL mid_counts got %0d/%0d want 0/0", rx_count, tx_count); end
        n_checks++;
        if (proc_rx_valid !== 1'b0 || host_tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valids got %b/%b want 0/0", proc_rx_valid, host_tx_valid); end
        n_checks++;
        if (host_rx_ready !== 1'b1 || proc_tx_ready !== 1'b1) begin n_fail++; $display("FAIL mid_readys got %b/%b want 1/1", host_rx_ready, proc_tx_ready); end
        n_checks++;
        if (err_underflow !== 1'b0 || err_overflow !== 1'b0) begin n_fail++; $display("FAIL mid_flags got %b/%b want 0/0", err_underflow, err_overflow); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            host_rx_valid = ($urandom_range(0, 3) != 0);
            host_rx_data  = 8'($urandom);
            proc_rx_rden  = ($urandom_range(0, 2) == 0);
            proc_tx_wren  = ($urandom_range(0, 2) != 0);
            proc_tx_data  = 8'($urandom);
            host_tx_ready = ($urandom_range(0, 3) == 0);
            tick();
            n_checks++;
            if (rx_count !== CNT_W'(rx_q.size()) || tx_count !== CNT_W'(tx_q.size())) begin n_fail++; $display("FAIL rand_count c=%0d got %0d/%0d want %0d/%0d", c, rx_count, tx_count, rx_q.size(), tx_q.size()); end
            n_checks++;
            if (host_rx_ready !== (rx_q.size() < DEPTH) || proc_tx_ready !== (tx_q.size() < DEPTH)) begin n_fail++; $display("FAIL rand_ready c=%0d got %b/%b", c, host_rx_ready, proc_tx_ready); end
            n_checks++;
            if (proc_rx_valid !== (rx_q.size() > 0) || host_tx_valid !== (tx_q.size() > 0)) begin n_fail++; $display("FAIL rand_valid c=%0d got %b/%b", c, proc_rx_valid, host_tx_valid); end
            if (rx_q.size() > 0) begin
                n_checks++;
                if (proc_rx_data !== rx_q[0]) begin n_fail++; $display("FAIL rand_rx_data c=%0d got %h want %h", c, proc_rx_data, rx_q[0]); end
            end
            if (tx_q.size() > 0) begin
                n_checks++;
                if (host_tx_data !== tx_q[0]) begin n_fail++; $display("FAIL rand_tx_data c=%0d got %h want %h", c, host_tx_data, tx_q[0]); end
            end
            n_checks++;
            if (err_underflow !== m_udf || err_overflow !== m_ovf) begin n_fail++; $display("FAIL rand_flags c=%0d got %b%b want %b%b", c, err_underflow, err_overflow, m_udf, m_ovf); end
        end
        idle();
    endtask

    initial begin
        m_udf = 0;
        m_ovf = 0;
        test_reset();
        test_rx_basic();
        test_tx_overflow();
        test_wrap();
        test_underflow();
        test_full_refuse();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
